// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: command handshake plus column-strobe/row-sense keypad lines
interface keypad_emulator_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] keypad_col;
  logic [3:0] keypad_row;
  logic       busy;
  logic       err;
  modport master (
    output key_code, key_valid, keypad_col,
    input  key_ready, keypad_row, busy, err
  );
  modport slave (
    input  key_code, key_valid, keypad_col,
    output key_ready, keypad_row, busy, err
  );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x3 matrix keypad device model with press, bounce, hold, release and gap sequencing
module keypad_emulator #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd1000,
  parameter logic [15:0] GAP_CYCLES    = 16'd500,
  parameter logic [7:0]  BOUNCE_CYCLES = 8'd0,
  parameter logic [3:0]  BOUNCE_PERIOD = 4'd3
) (
  input  logic               clk_3p33MHz,
  input  logic               reset_n,
  keypad_emulator_if.slave   kp
);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
  localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;
  localparam logic [15:0] GAP_LAST  = (GAP_CYCLES == 16'd0) ? 16'd0 : GAP_CYCLES - 16'd1;
  localparam logic [15:0] BNC_LAST  = {8'd0, BOUNCE_CYCLES} - 16'd1;
  localparam logic [3:0]  PER_LAST  = BOUNCE_PERIOD - 4'd1;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, last;
  logic [3:0]  pcnt_q, pcnt_d;
  logic        ph_q, ph_d;
  logic [1:0]  krow_q, krow_d, kcol_q, kcol_d, kr, kc;
  logic [3:0]  row_q, row_d;
  logic        err_q, err_d;
  logic        accept, code_ok, done, enter, ph_tick, hit, contact;
  always_ff @(posedge clk_3p33MHz) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      pcnt_q  <= 4'd0;
      ph_q    <= 1'b0;
      krow_q  <= 2'd0;
      kcol_q  <= 2'd0;
      row_q   <= 4'hF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      ph_q    <= ph_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    accept  = kp.key_valid && (state_q == IDLE);
    code_ok = (kp.key_code != 4'd0) && (kp.key_code <= 4'd12);
    kr      = 2'((kp.key_code - 4'd1) / 4'd3);
    kc      = 2'((kp.key_code - 4'd1) % 4'd3);
    last    = (state_q == HOLD) ? HOLD_LAST : (state_q == GAP) ? GAP_LAST : BNC_LAST;
    done    = cnt_q == last;
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = !code_ok ? GAP : (BOUNCE_CYCLES == 8'd0) ? HOLD : BOUNCE_IN;
      BOUNCE_IN:  if (done) state_d = HOLD;
      HOLD:       if (done) state_d = (BOUNCE_CYCLES == 8'd0) ? GAP : BOUNCE_OUT;
      BOUNCE_OUT: if (done) state_d = GAP;
      GAP:        if (done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    enter   = state_d != state_q;
    cnt_d   = (enter || state_q == IDLE) ? 16'd0 : (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    ph_tick = pcnt_q == PER_LAST;
    pcnt_d  = (enter || ph_tick) ? 4'd0 : pcnt_q + 4'd1;
    ph_d    = enter ? (state_d == BOUNCE_IN) : ph_q ^ ph_tick;
    krow_d  = accept ? kr : krow_q;
    kcol_d  = accept ? kc : kcol_q;
    err_d   = accept && !code_ok;
    // only the latched column gates the row; other low columns are ignored
    hit     = contact && !kp.keypad_col[kcol_q];
    row_d   = ~({3'b000, hit} << krow_q);
  end
  always_comb begin
    contact       = (state_q == HOLD) || ((state_q == BOUNCE_IN || state_q == BOUNCE_OUT) && ph_q);
    kp.busy       = state_q != IDLE;
    kp.key_ready  = state_q == IDLE;
    kp.err        = err_q;
    kp.keypad_row = row_q;
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of handshake, column gating, bounce, invalid codes and reset
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [2:0]  cols [3] = '{3'b110, 3'b101, 3'b011};
  logic [18:0] pat = 19'b0011000000110011111;
  keypad_emulator_if ifa ();
  keypad_emulator_if ifb ();
  keypad_emulator #(.HOLD_CYCLES(16'd8), .GAP_CYCLES(16'd4), .BOUNCE_CYCLES(8'd0), .BOUNCE_PERIOD(4'd3))
    dut_a (.clk_3p33MHz(clk), .reset_n(reset_n), .kp(ifa));
  keypad_emulator #(.HOLD_CYCLES(16'd4), .GAP_CYCLES(16'd3), .BOUNCE_CYCLES(8'd6), .BOUNCE_PERIOD(4'd2))
    dut_b (.clk_3p33MHz(clk), .reset_n(reset_n), .kp(ifb));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    ifa.key_valid = 1'b0; ifa.key_code = 4'd0; ifa.keypad_col = 3'b111;
    ifb.key_valid = 1'b0; ifb.key_code = 4'd0; ifb.keypad_col = 3'b111;
    tick(2);
    chk("rst_row", 8'(ifa.keypad_row), 8'hF);
    chk("rst_ready", 8'(ifa.key_ready), 8'd1);
    chk("rst_busy", 8'(ifa.busy), 8'd0);
    chk("rst_err", 8'(ifa.err), 8'd0);
    chk("rst_row_b", 8'(ifb.keypad_row), 8'hF);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifa.keypad_col = cols[i];
      tick(1);
      chk("idle_row", 8'(ifa.keypad_row), 8'hF);
      chk("idle_ready", 8'(ifa.key_ready), 8'd1);
      chk("idle_busy", 8'(ifa.busy), 8'd0);
      chk("idle_err", 8'(ifa.err), 8'd0);
    end
    ifa.keypad_col = 3'b101; ifa.key_code = 4'd5; ifa.key_valid = 1'b1;
    tick(1);
    ifa.key_valid = 1'b0;
    chk("p5_busy", 8'(ifa.busy), 8'd1);
    chk("p5_ready", 8'(ifa.key_ready), 8'd0);
    chk("p5_row0", 8'(ifa.keypad_row), 8'hF);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk("p5_hold_row", 8'(ifa.keypad_row), 8'hD);
    end
    tick(1);
    chk("p5_rel_row", 8'(ifa.keypad_row), 8'hF);
    chk("p5_gap_busy", 8'(ifa.busy), 8'd1);
    tick(2);
    chk("p5_busy11", 8'(ifa.busy), 8'd1);
    tick(1);
    chk("p5_busy12", 8'(ifa.busy), 8'd0);
    chk("p5_ready12", 8'(ifa.key_ready), 8'd1);
    ifa.keypad_col = 3'b111; ifa.key_code = 4'd12; ifa.key_valid = 1'b1;
    tick(1);
    ifa.key_valid = 1'b0;
    ifa.keypad_col = 3'b110; tick(1); chk("g12_c110", 8'(ifa.keypad_row), 8'hF);
    ifa.keypad_col = 3'b101; tick(1); chk("g12_c101", 8'(ifa.keypad_row), 8'hF);
    ifa.keypad_col = 3'b011; tick(1); chk("g12_c011", 8'(ifa.keypad_row), 8'h7);
    ifa.keypad_col = 3'b001; tick(1); chk("g12_c001", 8'(ifa.keypad_row), 8'h7);
    ifa.keypad_col = 3'b110; tick(1); chk("g12_c110b", 8'(ifa.keypad_row), 8'hF);
    ifa.keypad_col = 3'b011; tick(1); chk("g12_c011b", 8'(ifa.keypad_row), 8'h7);
    ifa.keypad_col = 3'b111;
    tick(6);
    chk("g12_ready", 8'(ifa.key_ready), 8'd1);
    ifa.keypad_col = 3'b000; ifa.key_code = 4'd0; ifa.key_valid = 1'b1;
    tick(1);
    ifa.key_valid = 1'b0;
    chk("inv_err", 8'(ifa.err), 8'd1);
    chk("inv_busy", 8'(ifa.busy), 8'd1);
    chk("inv_row", 8'(ifa.keypad_row), 8'hF);
    tick(1);
    chk("inv_err_off", 8'(ifa.err), 8'd0);
    chk("inv_row1", 8'(ifa.keypad_row), 8'hF);
    tick(2);
    chk("inv_busy3", 8'(ifa.busy), 8'd1);
    tick(1);
    chk("inv_busy4", 8'(ifa.busy), 8'd0);
    chk("inv_ready4", 8'(ifa.key_ready), 8'd1);
    ifa.keypad_col = 3'b011; ifa.key_code = 4'd3; ifa.key_valid = 1'b1;
    tick(1);
    chk("b2b_busy", 8'(ifa.busy), 8'd1);
    tick(8);
    chk("b2b_row8", 8'(ifa.keypad_row), 8'hE);
    tick(1);
    chk("b2b_row9", 8'(ifa.keypad_row), 8'hF);
    tick(2);
    chk("b2b_ready11", 8'(ifa.key_ready), 8'd0);
    tick(1);
    chk("b2b_ready12", 8'(ifa.key_ready), 8'd1);
    tick(1);
    chk("b2b_reaccept", 8'(ifa.busy), 8'd1);
    ifa.key_valid = 1'b0;
    tick(1);
    chk("b2b_row14", 8'(ifa.keypad_row), 8'hE);
    tick(11);
    chk("b2b_done", 8'(ifa.key_ready), 8'd1);
    ifa.keypad_col = 3'b110; ifa.key_code = 4'd7; ifa.key_valid = 1'b1;
    tick(1);
    ifa.key_valid = 1'b0;
    tick(3);
    chk("r7_row", 8'(ifa.keypad_row), 8'hB);
    reset_n = 1'b0;
    tick(1);
    chk("r7_rst_row", 8'(ifa.keypad_row), 8'hF);
    chk("r7_rst_ready", 8'(ifa.key_ready), 8'd1);
    chk("r7_rst_busy", 8'(ifa.busy), 8'd0);
    reset_n = 1'b1;
    ifa.keypad_col = 3'b101; ifa.key_code = 4'd5; ifa.key_valid = 1'b1;
    tick(1);
    ifa.key_valid = 1'b0;
    chk("r7_after_busy", 8'(ifa.busy), 8'd1);
    tick(1);
    chk("r7_after_row", 8'(ifa.keypad_row), 8'hD);
    ifb.keypad_col = 3'b110; ifb.key_code = 4'd1; ifb.key_valid = 1'b1;
    tick(1);
    ifb.key_valid = 1'b0;
    chk("bnc_busy", 8'(ifb.busy), 8'd1);
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      chk("bnc_row", 8'({3'b111, pat[19-k]}), 8'(ifb.keypad_row));
      chk("bnc_busy_k", 8'(ifb.busy), 8'(k < 19));
    end
    chk("bnc_ready", 8'(ifb.key_ready), 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Emulates a 4-row x 3-column matrix keypad: it is the responding end of the column-strobe/row-sense keypad interface.
- It takes a 4-bit key code from a valid/ready command port.
- It then presents that key as closed on the row lines whenever the scanner drives the key's column low.
- It sequences press, optional contact bounce, hold and release.
- Used on-board as a loopback stimulus source for the keypad scanner, and in benches as the scanner's device model.

Parameters:
- HOLD_CYCLES, 16'd1000, cycles the key stays cleanly closed after bounce.
- GAP_CYCLES, 16'd500, cycles of guaranteed release after a key before the next command is accepted.
- BOUNCE_CYCLES, 8'd0, length of the bounce phase at press and at release; 0 disables bounce.
- BOUNCE_PERIOD, 4'd3, contact state toggles every BOUNCE_PERIOD cycles during bounce; must be >=1.

Ports:
- clk_3p33MHz  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- key_code  input  4  key to press: 1..12 valid; 0 and 13..15 invalid.
- key_valid  input  1  command present.
- key_ready  output  1  emulator can accept a command.
- keypad_col  input  3  column strobes, active-low; bit c = COL_c.
- keypad_row  output  4  row sense, active-low, idle high (emulates pull-ups); bit r = ROW_r.
- busy  output  1  high from acceptance until end of GAP.
- err  output  1  one-cycle pulse when an invalid code is accepted.

Behaviour:
- Clock and reset: one clock, clk_3p33MHz. Reset is synchronous and active-low on reset_n; all state is updated only on the rising clock edge.
- Reset values (reset_n low at a rising edge):
  - state=IDLE, key_ready=1, busy=0, err=0.
  - keypad_row=4'b1111, counters=0, latched key cleared.
  - Reset mid-press releases the key on the same edge.
- Key mapping: index i = key_code-1; row r = i/3; column c = i%3. Example: code 1 is row0/col0, code 5 is row1/col1, code 12 is row3/col2.
- Handshake:
  - A command is accepted on a rising edge with key_valid=1 and key_ready=1; key_code is latched on that edge.
  - key_ready=1 only in IDLE.
  - key_code is ignored when no command is accepted.
- Contact state:
  - An internal contact bit is 1 when the key is closed.
  - keypad_row is registered: each cycle keypad_row[r] <= ~(contact & (r==row) & ~keypad_col[col]); all other rows stay 1.
  - Latency from keypad_col change to keypad_row response is exactly 1 cycle.
  - If several columns are low at once, only the latched column matters.
- State machine (counters restart at 0 on every state entry):
  - IDLE: contact=0. On accepting a valid code go to BOUNCE_IN, or to HOLD if BOUNCE_CYCLES=0. On accepting an invalid code, pulse err for 1 cycle and go to GAP (no press).
  - BOUNCE_IN: contact starts at 1 and toggles every BOUNCE_PERIOD cycles. After BOUNCE_CYCLES cycles go to HOLD.
  - HOLD: contact=1 for HOLD_CYCLES cycles, then go to BOUNCE_OUT, or to GAP if BOUNCE_CYCLES=0.
  - BOUNCE_OUT: contact starts at 0 and toggles every BOUNCE_PERIOD cycles. After BOUNCE_CYCLES cycles go to GAP.
  - GAP: contact=0 for GAP_CYCLES cycles, then go to IDLE.
  - A cycle count of 0 for HOLD or GAP is treated as 1 cycle.
- busy:
  - Goes 1 on the acceptance edge and returns to 0 on the edge entering IDLE; key_ready is its complement.
  - Total busy time with BOUNCE_CYCLES=0 is HOLD_CYCLES+GAP_CYCLES cycles.
- Counters: 16-bit, saturate and never wrap. Terminal compare is count==limit-1.
- Simultaneous events:
  - key_valid held high through a transfer is not re-accepted until IDLE.
  - A new command can be accepted on the same edge that IDLE is re-entered only from the following cycle, because key_ready is registered.

Test Plan:
- Reset and idle:
  - Stimulus: reset_n=0 for 2 cycles, then release; keypad_col toggles through 110/101/011.
  - Required: keypad_row=1111, key_ready=1, busy=0, err=0 throughout.
- Single press of code 5 (HOLD=8, GAP=4, BOUNCE=0), keypad_col=3'b101:
  - keypad_row=4'b1101 starting 1 cycle after acceptance, for 8 cycles.
  - Then 1111; busy high for 12 cycles; key_ready returns to 1.
- Column gating, code 12 pressed while columns are scanned:
  - keypad_row[3]=0 only in the cycle after keypad_col=011.
  - keypad_row=1111 whenever col2 is high.
- Bounce (BOUNCE_CYCLES=6, BOUNCE_PERIOD=2), code 1 with col0 held low:
  - row0 sequence after acceptance is 0,0,1,1,0,0, then 0 for HOLD.
  - Release sequence is 1,1,0,0,1,1, then 1 for GAP.
- Invalid and back-to-back:
  - Code 0 accepted: err pulses 1 cycle, no row activity, busy high for GAP cycles.
  - key_valid held with code 3: second press starts only after key_ready is re-asserted.
- Reset mid-HOLD:
  - Assert reset_n=0 during HOLD of code 7.
  - Required: keypad_row=1111 and key_ready=1 on the next edge, then normal operation.
